// File: rtl/pla_bist_pkg.sv
// pla_bist_pkg
//   Shared definitions for the PLA built-in self-test drivers: interface
//   widths, LFSR/MISR tap masks, the driver state encoding and the LFSR
//   step/seed helpers.
package pla_bist_pkg;

  localparam int unsigned PLA_IN_W  = 32;
  localparam int unsigned PLA_OUT_W = 20;

  // Tap masks: a set bit i means state bit i feeds the XOR feedback.
  // LFSR: x31 ^ x21 ^ x1 ^ x0.   MISR: m19 ^ m16.
  localparam logic [PLA_IN_W-1:0]  LFSR_TAPS = 32'h80200003;
  localparam logic [PLA_OUT_W-1:0] MISR_TAPS = 20'h90000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

  // One shift of the stimulus LFSR: shift left, feedback into bit 0.
  function automatic logic [PLA_IN_W-1:0] lfsr_step(input logic [PLA_IN_W-1:0] s);
    return {s[PLA_IN_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  function automatic logic [PLA_IN_W-1:0] seed_fix(input logic [PLA_IN_W-1:0] s);
    return (s == '0) ? {{(PLA_IN_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/pla_bist_misr.sv
// pla_bist_misr
//   Multiple-input signature register. Each enabled cycle the register
//   shifts left with XOR feedback from the TAPS bits into bit 0, and the
//   parallel input word is XORed over the result.
// Ports
//   clk      clock
//   rst      asynchronous active-high reset, clears the signature
//   clr      synchronous clear (has priority over en)
//   en       absorb din this cycle
//   din      parallel data word to compress
//   sig      signature register
//   sig_next value sig takes on an enabled cycle (combinational)
module pla_bist_misr
  import pla_bist_pkg::*;
#(
  parameter int unsigned        DATA_W = PLA_OUT_W,
  parameter logic [DATA_W-1:0]  TAPS   = MISR_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sig,
  output logic [DATA_W-1:0] sig_next
);

  function automatic logic [DATA_W-1:0] misr_step(input logic [DATA_W-1:0] s,
                                                  input logic [DATA_W-1:0] d);
    return {s[DATA_W-2:0], ^(s & TAPS)} ^ d;
  endfunction

  always_comb sig_next = misr_step(sig, din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/pla_bist_driver.sv
// pla_bist_driver
//   BIST driver for a 32-input / 20-output combinational PLA. A run applies
//   NUM_VECTORS LFSR patterns on pla_x, compresses the PLA response pla_z
//   into a MISR and, at the end, compares the signature with expected_sig.
// Parameters
//   NUM_VECTORS vectors per run (1..65535)
//   SEED        LFSR start state (0 is replaced by 1)
//   CNT_W       vector counter width, 2**CNT_W > NUM_VECTORS
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start, abort  one-cycle control pulses (abort wins when both are high)
//   expected_sig  golden signature, held stable while done=1
//   pla_z         PLA outputs z00..z19
//   pla_x         PLA inputs x00..x31, straight from the LFSR register
//   busy, done    high in RUN / DONE respectively
//   pass          signature match result, valid while done=1
//   signature     MISR contents, kept visible until the next start or rst
module pla_bist_driver
  import pla_bist_pkg::*;
#(
  parameter int unsigned         NUM_VECTORS = 1024,
  parameter logic [PLA_IN_W-1:0] SEED        = 32'h00000001,
  parameter int unsigned         CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PLA_OUT_W-1:0] expected_sig,
  input  logic [PLA_OUT_W-1:0] pla_z,
  output logic [PLA_IN_W-1:0]  pla_x,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [PLA_OUT_W-1:0] signature
);

  localparam logic [PLA_IN_W-1:0] SEED_EFF = seed_fix(SEED);
  localparam logic [CNT_W-1:0]    LAST     = CNT_W'(NUM_VECTORS - 1);

  bist_state_t           state;
  logic [PLA_IN_W-1:0]   lfsr;
  logic [CNT_W-1:0]      cnt;
  logic                  misr_clr;
  logic                  misr_en;
  logic [PLA_OUT_W-1:0]  sig_next;

  assign pla_x = lfsr;

  // The PLA is purely combinational, so z for the current pla_x is absorbed
  // on the same edge that advances the LFSR. An aborted cycle absorbs nothing.
  always_comb begin
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state)
      IDLE:    misr_clr = start;
      RUN:     misr_en  = ~abort;
      DONE:    misr_clr = start & ~abort;
      default: begin
        misr_clr = 1'b0;
        misr_en  = 1'b0;
      end
    endcase
  end

  pla_bist_misr #(
    .DATA_W (PLA_OUT_W),
    .TAPS   (MISR_TAPS)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .clr      (misr_clr),
    .en       (misr_en),
    .din      (pla_z),
    .sig      (signature),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr  <= SEED_EFF;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // The LFSR also steps on the final vector; that value is never used.
            lfsr <= lfsr_step(lfsr);
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              // Compare against the signature being written this edge so that
              // pass is valid in the same cycle done rises.
              pass  <= (sig_next == expected_sig);
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (abort) begin
            done  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else if (start) begin
            lfsr  <= SEED_EFF;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
            state <= RUN;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pla_bist_driver.sv
// tb_pla_bist_driver
//   Directed sequence with randomized PLA responses for three driver
//   instances: dut_a (4 vectors, SEED=1), dut_s (4 vectors, SEED=0, shares
//   dut_a's inputs) and dut_b (1024 vectors driving a PLA model).
module tb_pla_bist_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [19:0] expected_sig = '0;
  logic [19:0] pla_z = '0;
  logic [31:0] x_a, x_s, x_b;
  logic        busy_a, done_a, pass_a;
  logic        busy_s, done_s, pass_s;
  logic [19:0] sig_a, sig_s;

  logic        start_b = 1'b0;
  logic        abort_b = 1'b0;
  logic [19:0] expected_b = '0;
  logic [19:0] z_b;
  logic        busy_b, done_b, pass_b;
  logic [19:0] sig_b;

  int npass = 0;
  int nchk  = 0;

  localparam logic [31:0] SEED_B = 32'hC0FFEE11;

  always #5 clk = ~clk;

  pla_bist_driver #(.NUM_VECTORS(4), .SEED(32'h00000001), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_sig(expected_sig),
    .pla_z(pla_z), .pla_x(x_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a));

  pla_bist_driver #(.NUM_VECTORS(4), .SEED(32'h00000000), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_sig(expected_sig),
    .pla_z(pla_z), .pla_x(x_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .signature(sig_s));

  pla_bist_driver #(.NUM_VECTORS(1024), .SEED(SEED_B), .CNT_W(11)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .expected_sig(expected_b),
    .pla_z(z_b), .pla_x(x_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b));

  // Reference rules: the LFSR feeds back x31^x21^x1^x0 into bit 0, the MISR
  // feeds back m19^m16 into bit 0 and XORs the PLA response on top.
  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return (s << 1) | {31'd0, fb};
  endfunction

  function automatic logic [19:0] ref_misr(input logic [19:0] m, input logic [19:0] z);
    logic fb;
    fb = m[19] ^ m[16];
    return ((m << 1) | {19'd0, fb}) ^ z;
  endfunction

  // Arbitrary two-level AND/OR function standing in for a generated PLA.
  function automatic logic [19:0] pla_fn(input logic [31:0] x);
    logic [19:0] z;
    for (int i = 0; i < 20; i++)
      z[i] = (x[i] & x[(i + 7) % 32]) | (~x[(i * 3 + 5) % 32] & x[(i + 12) % 32])
           | (x[31 - i] & ~x[i + 1]);
    return z;
  endfunction

  always_comb z_b = pla_fn(x_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    nchk++;
    assert (obs === req) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs dut_b from a start pulse to done, with random start pulses during RUN.
  task automatic run_b(output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    while (!done_b && guard < 3000) begin
      if (busy_b) nbusy++;
      start_b = ($urandom_range(0, 7) == 0);
      tick();
      guard++;
    end
    start_b = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_x [4];
    logic [19:0] zr [4];
    logic [19:0] m;
    logic [19:0] r1, r2;
    logic [31:0] s;
    logic [19:0] sig_b_model;
    int nbusy;

    exp_x[0] = 32'h1; exp_x[1] = 32'h3; exp_x[2] = 32'h6; exp_x[3] = 32'hD;

    // Reset state
    tick(); tick();
    check("rst_x", x_a, 0);
    check("rst_sig", {12'd0, sig_a}, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    rst = 1'b0;
    tick();

    // Abort in IDLE is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_busy", busy_a, 0);

    // Run 1: z tied to 0, SEED=1 and SEED=0 instances in lockstep
    pla_z = '0; expected_sig = '0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("x_seq%0d", i), x_a, exp_x[i]);
      check($sformatf("x_seq_rule%0d", i), exp_x[i], (i == 0) ? 32'h1 : ref_lfsr(exp_x[i-1]));
      check($sformatf("x_seed0_%0d", i), x_s, exp_x[i]);
      check($sformatf("busy%0d", i), busy_a, 1);
      tick();
    end
    check("run1_busy_end", busy_a, 0);
    check("run1_done", done_a, 1);
    check("run1_pass", pass_a, 1);
    check("run1_sig", {12'd0, sig_a}, 0);
    check("run1_seed0_done", done_s, 1);

    // Run 2: z tied to 1, restarted from DONE
    pla_z = 20'h00001; expected_sig = 20'h0000F;
    m = '0;
    for (int i = 0; i < 4; i++) m = ref_misr(m, 20'h00001);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_done_clr", done_a, 0);
    check("restart_busy", busy_a, 1);
    repeat (4) tick();
    check("z1_sig", {12'd0, sig_a}, {12'd0, m});
    check("z1_sig_const", {12'd0, sig_a}, 32'hF);
    check("z1_pass", pass_a, 1);
    check("z1_seed0_sig", {12'd0, sig_s}, {12'd0, m});

    expected_sig = 20'h0000E;
    abort = 1'b1; tick(); abort = 1'b0;
    check("done_abort_done", done_a, 0);
    check("done_abort_pass", pass_a, 0);
    check("done_abort_sig", {12'd0, sig_a}, 32'hF);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("z1_fail_done", done_a, 1);
    check("z1_fail_pass", pass_a, 0);

    // Abort at the second RUN cycle, together with start
    r1 = 20'($urandom); r2 = 20'($urandom);
    start = 1'b1; tick(); start = 1'b0;
    pla_z = r1; tick();
    pla_z = r2; abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_sig", {12'd0, sig_a}, {12'd0, ref_misr(20'd0, r1)});
    tick(); tick();
    check("abort_stays_idle", busy_a, 0);
    check("abort_sig_hold", {12'd0, sig_a}, {12'd0, r1});

    // Asynchronous reset between edges in RUN
    start = 1'b1; tick(); start = 1'b0;
    pla_z = 20'($urandom); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst_x", x_a, 0);
    check("arst_sig", {12'd0, sig_a}, 0);
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_pass", pass_a, 0);
    #1 rst = 1'b0;
    tick();

    // Random responses after reset; first-run sequence must repeat
    m = '0;
    for (int i = 0; i < 4; i++) begin
      zr[i] = 20'($urandom);
      m = ref_misr(m, zr[i]);
    end
    expected_sig = m;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_rst_x%0d", i), x_a, exp_x[i]);
      pla_z = zr[i];
      tick();
    end
    check("rand_done", done_a, 1);
    check("rand_sig", {12'd0, sig_a}, {12'd0, m});
    check("rand_pass", pass_a, 1);

    // 1024-vector run against the PLA model
    s = SEED_B; sig_b_model = '0;
    for (int k = 0; k < 1024; k++) begin
      sig_b_model = ref_misr(sig_b_model, pla_fn(s));
      s = ref_lfsr(s);
    end
    expected_b = sig_b_model;
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("b_first_x", x_b, SEED_B);
    run_b(nbusy);
    check("b_done", done_b, 1);
    check("b_busy_cycles", nbusy, 1024);
    check("b_sig", {12'd0, sig_b}, {12'd0, sig_b_model});
    check("b_pass", pass_b, 1);

    start_b = 1'b1; tick(); start_b = 1'b0;
    check("b_restart_done", done_b, 0);
    check("b_restart_busy", busy_b, 1);
    run_b(nbusy);
    check("b2_done", done_b, 1);
    check("b2_busy_cycles", nbusy, 1024);
    check("b2_sig", {12'd0, sig_b}, {12'd0, sig_b_model});
    check("b2_pass", pass_b, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
